regwrite_trace_fifo: RTL and testbench

- Synthesizable register-file write tracer for the MIPS single-cycle and pipelined cores.
- Snoops NPORTS register-file write ports every cycle and timestamps each architectural write with a free-running cycle counter.
- Buffers events in a multi-push FIFO; a valid/ready drain port feeds a host or bench.
- Replaces per-cycle register dumps in simulation with an event stream that also works on silicon.

---
 rtl/regwrite_trace_fifo.sv | 151 +++++++++++++++
 tb/tb_regwrite_trace_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_trace_fifo.sv
// rtl/regwrite_trace_fifo.sv - timestamped multi-port register-write tracer with FWFT drain FIFO
// Optional build macro TRACE_CHANGE_ONLY_EN: trace only writes that change the register value.
module regwrite_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16,
    parameter int OVF_W  = 8,
    localparam int PORT_W = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NPORTS-1:0]        wr_en,
    input  logic [NPORTS*ADDR_W-1:0] wr_addr,
    input  logic [NPORTS*DATA_W-1:0] wr_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [CYC_W-1:0]         trace_cycle,
    output logic [PORT_W-1:0]        trace_port,
    output logic [ADDR_W-1:0]        trace_addr,
    output logic [DATA_W-1:0]        trace_data,
    output logic [LVL_W-1:0]         level,
    output logic [OVF_W-1:0]         overflow_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [CYC_W-1:0]  cyc;
    logic [PTR_W-1:0]  wptr, rptr;
    logic [LVL_W-1:0]  lvl;
    logic [OVF_W-1:0]  ovf;

    logic [CYC_W-1:0]  mem_cyc  [DEPTH];
    logic [PORT_W-1:0] mem_port [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [CYC_W-1:0]  hold_cyc;
    logic [PORT_W-1:0] hold_port;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    logic [NPORTS-1:0] qual, accept;
    logic [PTR_W-1:0]  slot [NPORTS];
    logic [LVL_W-1:0]  free, n_acc, n_drop;
    logic [OVF_W:0]    ovf_sum;
    logic              pop;

`ifdef TRACE_CHANGE_ONLY_EN
    logic [DATA_W-1:0] shadow [2**ADDR_W];
`endif

    assign trace_valid  = (lvl != '0);
    assign pop          = trace_valid && trace_ready;
    assign level        = lvl;
    assign overflow_cnt = ovf;

    // Free space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    always_comb begin
        free    = LVL_W'(DEPTH) - lvl;
        n_acc   = '0;
        n_drop  = '0;
        qual    = '0;
        accept  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            qual[p] = enable && wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0);
`ifdef TRACE_CHANGE_ONLY_EN
            if (wr_data[p*DATA_W +: DATA_W] == shadow[wr_addr[p*ADDR_W +: ADDR_W]])
                qual[p] = 1'b0;
`endif
            slot[p] = wptr + PTR_W'(n_acc);
            if (qual[p]) begin
                if (n_acc < free) begin
                    accept[p] = 1'b1;
                    n_acc     = n_acc + LVL_W'(1);
                end else begin
                    n_drop = n_drop + LVL_W'(1);
                end
            end
        end
        ovf_sum = {1'b0, ovf} + (OVF_W+1)'(n_drop);
    end

    always_comb begin
        if (trace_valid) begin
            trace_cycle = mem_cyc[rptr];
            trace_port  = mem_port[rptr];
            trace_addr  = mem_addr[rptr];
            trace_data  = mem_data[rptr];
        end else begin
            trace_cycle = hold_cyc;
            trace_port  = hold_port;
            trace_addr  = hold_addr;
            trace_data  = hold_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            lvl       <= '0;
            ovf       <= '0;
            hold_cyc  <= '0;
            hold_port <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            cyc  <= cyc + CYC_W'(1);
            wptr <= wptr + PTR_W'(n_acc);
            rptr <= rptr + PTR_W'(pop);
            lvl  <= lvl + n_acc - LVL_W'(pop);
            ovf  <= ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
            if (trace_valid) begin
                hold_cyc  <= trace_cycle;
                hold_port <= trace_port;
                hold_addr <= trace_addr;
                hold_data <= trace_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (!rst && accept[p]) begin
                mem_cyc[slot[p]]  <= cyc;
                mem_port[slot[p]] <= PORT_W'(p);
                mem_addr[slot[p]] <= wr_addr[p*ADDR_W +: ADDR_W];
                mem_data[slot[p]] <= wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

`ifdef TRACE_CHANGE_ONLY_EN
    // Ascending port order lets the higher port win an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 2**ADDR_W; r++)
                shadow[r] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++)
                if (enable && wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0))
                    shadow[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
    end
`endif

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// tb/tb_regwrite_trace_fifo.sv - scoreboard bench for regwrite_trace_fifo
module tb_regwrite_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        trace_ready;
    logic        trace_valid;
    logic [15:0] trace_cycle;
    logic        trace_port;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [4:0]  level;
    logic [7:0]  overflow_cnt;

    logic        en4, rdy4, v4, p4;
    logic [1:0]  we4;
    logic [9:0]  wa4;
    logic [63:0] wd4;
    logic [3:0]  c4;
    logic [4:0]  a4, l4;
    logic [31:0] d4;
    logic [7:0]  o4;

    regwrite_trace_fifo u_dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_cycle(trace_cycle), .trace_port(trace_port), .trace_addr(trace_addr),
        .trace_data(trace_data), .level(level), .overflow_cnt(overflow_cnt)
    );

    regwrite_trace_fifo #(.CYC_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .enable(en4), .wr_en(we4), .wr_addr(wa4),
        .wr_data(wd4), .trace_valid(v4), .trace_ready(rdy4),
        .trace_cycle(c4), .trace_port(p4), .trace_addr(a4),
        .trace_data(d4), .level(l4), .overflow_cnt(o4)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb [$];
    int          exp_ovf;
    logic [15:0] cyc_m;
`ifdef TRACE_CHANGE_ONLY_EN
    logic [31:0] shadow_m [32];
`endif

    always @(posedge clk) cyc_m <= rst ? 16'd0 : cyc_m + 16'd1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] c, input logic p,
                                         input logic [4:0] a, input logic [31:0] d);
        return {10'd0, c, p, a, d};
    endfunction

    task automatic drive_idle();
        enable = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; trace_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_ovf = 0;
`ifdef TRACE_CHANGE_ONLY_EN
        for (int r = 0; r < 32; r++) shadow_m[r] = '0;
`endif
        check_eq("rst_valid", trace_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_ovf", overflow_cnt, 0);
        check_eq("rst_data", {trace_cycle, trace_data}, 0);
    endtask

    // One cycle: check state left by the previous cycle, pop/compare, then drive and model pushes.
    task automatic step(input logic en, input logic [1:0] we, input logic [4:0] a0,
                        input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1,
                        input logic rdy);
        int          start_lvl;
        int          acc;
        logic [4:0]  a;
        logic [31:0] d;
        logic        q;
        @(posedge clk); #1;
        check_eq("level", level, sb.size());
        check_eq("valid", trace_valid, sb.size() != 0);
        check_eq("ovf", overflow_cnt, exp_ovf);
        start_lvl = sb.size();
        if (rdy && start_lvl > 0) begin
            check_eq("head", pack(trace_cycle, trace_port, trace_addr, trace_data), sb[0]);
            void'(sb.pop_front());
        end
        enable = en; wr_en = we; wr_addr = {a1, a0}; wr_data = {d1, d0}; trace_ready = rdy;
        acc = 0;
        for (int p = 0; p < 2; p++) begin
            a = p ? a1 : a0;
            d = p ? d1 : d0;
            q = en && we[p] && (a != 0);
`ifdef TRACE_CHANGE_ONLY_EN
            if (d == shadow_m[a]) q = 1'b0;
`endif
            if (q) begin
                if (acc < DEPTH - start_lvl) begin
                    sb.push_back(pack(cyc_m, p[0], a, d));
                    acc++;
                end else if (exp_ovf < 255) begin
                    exp_ovf++;
                end
            end
        end
`ifdef TRACE_CHANGE_ONLY_EN
        for (int p = 0; p < 2; p++)
            if (en && we[p] && ((p ? a1 : a0) != 0)) shadow_m[p ? a1 : a0] = p ? d1 : d0;
`endif
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rdy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        drive_idle();
        en4 = 1'b0; we4 = '0; wa4 = '0; wd4 = '0; rdy4 = 1'b0;
        do_reset();

        // Single write stamped at cycle 3, then pop
        idle(0); idle(0);
        step(1, 2'b01, 5'd8, 32'h5, 5'd0, 32'd0, 0);
        idle(0);
        check_eq("stamp3", {trace_cycle, trace_port, trace_addr, trace_data},
                 {16'd3, 1'b0, 5'd8, 32'd5});
        idle(1);
        idle(0);

        // Writes to $zero are never traced
        step(1, 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 0);
        idle(0);
        check_eq("zero_level", level, 0);

        // Dual port ordering
        step(1, 2'b11, 5'd16, 32'd1, 5'd17, 32'd2, 0);
        idle(0);
        check_eq("dual_level", level, 2);
        idle(1); idle(1); idle(0);

        // Enable low suppresses capture
        step(0, 2'b11, 5'd3, 32'd9, 5'd4, 32'd9, 0);
        idle(0);

        // Fill to 15, then overflow by one
        for (int i = 0; i < 15; i++)
            step(1, 2'b01, 5'($urandom_range(1, 31)), $urandom, 5'd0, 32'd0, 0);
        step(1, 2'b11, 5'd20, 32'hA0, 5'd21, 32'hA1, 0);
        idle(0);
        check_eq("full_level", level, 16);
        check_eq("ovf_one", overflow_cnt, 1);

        // Full with a simultaneous pop: both pushes dropped
        step(1, 2'b11, 5'd22, 32'hB0, 5'd23, 32'hB1, 1);
        idle(0);
        check_eq("popfull_level", level, 15);
        check_eq("ovf_three", overflow_cnt, 3);

        // Saturation
        for (int i = 0; i < 300; i++)
            step(1, 2'b11, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom, 0);
        idle(0);
        check_eq("ovf_sat", overflow_cnt, 255);
        for (int i = 0; i < 18; i++) idle(1);
        check_eq("drained", level, 0);

        // Mixed traffic with a random consumer
        for (int i = 0; i < 60; i++)
            step(1, 2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom, 1'($urandom));
        for (int i = 0; i < 20; i++) idle(1);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2'b01, 5'(i + 1), 32'(i), 5'd0, 32'd0, 0);
        idle(0);
        check_eq("mid_level", level, 5);
        do_reset();
        step(1, 2'b10, 5'd0, 32'd0, 5'd12, 32'hC, 0);
        idle(0);
        check_eq("post_rst_stamp", trace_cycle, 1);
        idle(1); idle(0);

        // Timestamp wrap on the 4-bit counter instance
        do_reset();
        for (int i = 0; i < 17; i++) idle(0);
        en4 = 1'b1; we4 = 2'b01; wa4 = {5'd0, 5'd7}; wd4 = {32'd0, 32'h77};
        @(posedge clk); #1;
        en4 = 1'b0; we4 = '0;
        check_eq("wrap_valid", v4, 1);
        check_eq("wrap_stamp", c4, 1);
        check_eq("wrap_data", d4, 32'h77);

`ifdef TRACE_CHANGE_ONLY_EN
        do_reset();
        step(1, 2'b01, 5'd9, 32'd7, 5'd0, 32'd0, 0);
        step(1, 2'b01, 5'd9, 32'd7, 5'd0, 32'd0, 0);
        step(1, 2'b01, 5'd9, 32'd0, 5'd0, 32'd0, 0);
        step(1, 2'b01, 5'd10, 32'd0, 5'd0, 32'd0, 0);
        idle(0);
        check_eq("chg_level", level, 2);
        idle(1); idle(1); idle(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
